// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory requests, stalls upstream on slow accesses,
// and registers the MEM/WB write-back fields. Dump or timeout parks the stage in HALT.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] aluOutput_in,
  input  logic [15:0] B_in,
  input  logic        DMemEn_in,
  input  logic        DMemWrite_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic        DMemDump_in,
  input  logic [2:0]  WriteRegister_in,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        mem_dump,
  output logic [15:0] wbData_out,
  output logic [2:0]  WriteRegister_out,
  output logic        RegWrite_out,
  output logic        valid_out,
  output logic        stall_out,
  output logic        halt_out,
  output logic        err_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StHalt} state_e;

  state_e      stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic [15:0] holdAddrQ, holdAddrD;
  logic [15:0] holdDataQ, holdDataD;
  logic        holdWriteQ, holdWriteD;
  logic        holdMemToRegQ, holdMemToRegD;
  logic        holdRegWriteQ, holdRegWriteD;
  logic [2:0]  holdWregQ, holdWregD;
  logic        errQ, errD;
  logic [15:0] wbQ, wbD;
  logic [2:0]  wregQ, wregD;
  logic        regWriteQ, regWriteD;
  logic        validQ, validD;

  logic [15:0] addrC, wdataC;
  logic        rdC, wrC, dumpC, stallC;

  always_comb begin
    stateD        = stateQ;
    cntD          = cntQ;
    holdAddrD     = holdAddrQ;
    holdDataD     = holdDataQ;
    holdWriteD    = holdWriteQ;
    holdMemToRegD = holdMemToRegQ;
    holdRegWriteD = holdRegWriteQ;
    holdWregD     = holdWregQ;
    errD          = errQ;
    wbD           = wbQ;
    wregD         = wregQ;
    regWriteD     = 1'b0;
    validD        = 1'b0;
    addrC         = 16'h0000;
    wdataC        = 16'h0000;
    rdC           = 1'b0;
    wrC           = 1'b0;
    dumpC         = 1'b0;
    stallC        = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (valid_in) begin
          if (DMemDump_in) begin
            dumpC  = 1'b1;
            stateD = StHalt;
          end else if (DMemEn_in) begin
            addrC  = aluOutput_in;
            wdataC = B_in;
            wrC    = DMemWrite_in;
            rdC    = ~DMemWrite_in;
            if (mem_done) begin
              wbD       = MemToReg_in ? mem_rdata : aluOutput_in;
              wregD     = WriteRegister_in;
              regWriteD = RegWrite_in;
              validD    = 1'b1;
            end else begin
              holdAddrD     = aluOutput_in;
              holdDataD     = B_in;
              holdWriteD    = DMemWrite_in;
              holdMemToRegD = MemToReg_in;
              holdRegWriteD = RegWrite_in;
              holdWregD     = WriteRegister_in;
              cntD          = 4'd0;
              stallC        = 1'b1;
              stateD        = StBusy;
            end
          end else begin
            wbD       = aluOutput_in;
            wregD     = WriteRegister_in;
            regWriteD = RegWrite_in;
            validD    = 1'b1;
          end
        end
      end
      StBusy: begin
        addrC  = holdAddrQ;
        wdataC = holdDataQ;
        wrC    = holdWriteQ;
        rdC    = ~holdWriteQ;
        stallC = 1'b1;
        if (mem_done) begin
          stallC    = 1'b0;
          wbD       = holdMemToRegQ ? mem_rdata : holdAddrQ;
          wregD     = holdWregQ;
          regWriteD = holdRegWriteQ;
          validD    = 1'b1;
          stateD    = StIdle;
        end else if (cntQ == 4'd15) begin
          errD   = 1'b1;
          stateD = StHalt;
        end else begin
          cntD = cntQ + 4'd1;
        end
      end
      StHalt: begin
        stallC = 1'b1;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ        <= StIdle;
      cntQ          <= 4'd0;
      holdAddrQ     <= 16'h0000;
      holdDataQ     <= 16'h0000;
      holdWriteQ    <= 1'b0;
      holdMemToRegQ <= 1'b0;
      holdRegWriteQ <= 1'b0;
      holdWregQ     <= 3'd0;
      errQ          <= 1'b0;
      wbQ           <= 16'h0000;
      wregQ         <= 3'd0;
      regWriteQ     <= 1'b0;
      validQ        <= 1'b0;
    end else begin
      stateQ        <= stateD;
      cntQ          <= cntD;
      holdAddrQ     <= holdAddrD;
      holdDataQ     <= holdDataD;
      holdWriteQ    <= holdWriteD;
      holdMemToRegQ <= holdMemToRegD;
      holdRegWriteQ <= holdRegWriteD;
      holdWregQ     <= holdWregD;
      errQ          <= errD;
      wbQ           <= wbD;
      wregQ         <= wregD;
      regWriteQ     <= regWriteD;
      validQ        <= validD;
    end
  end

  // Combinational request outputs are masked while reset is held so nothing leaks out.
  assign mem_addr          = rst ? addrC : 16'h0000;
  assign mem_wdata         = rst ? wdataC : 16'h0000;
  assign mem_rd            = rst & rdC;
  assign mem_wr            = rst & wrC;
  assign mem_dump          = rst & dumpC;
  assign stall_out         = rst & stallC;
  assign halt_out          = (stateQ == StHalt);
  assign err_out           = errQ;
  assign wbData_out        = wbQ;
  assign WriteRegister_out = wregQ;
  assign RegWrite_out      = regWriteQ;
  assign valid_out         = validQ;

endmodule
